// File: rtl/layer_seq.sv
// layer_seq: time-multiplexed fully-connected neural layer.
//
// One signed-weight x unsigned-input multiply-accumulate per clock. Each
// neuron takes LENGHT_I MAC cycles followed by one activation cycle, so a
// full vector completes LENGHT_O*(LENGHT_I+1) cycles after it is accepted.
// The activation is a hard sigmoid: (acc >>> SHIFT) + 2^(WIDTH_O-1), clamped
// to [0, 2^WIDTH_O-1].
//
// Optional feature: define LAYER_SEQ_BIAS_EN to add the per-neuron signed
// bias port b_i; the accumulator then starts each neuron at b[o] and grows
// by one bit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in / w_i (/ b_i) valid
//   in_ready   block is idle and can accept a vector
//   w_i        LENGHT_I*LENGHT_O signed weights, element o*LENGHT_I+i
//   b_i        LENGHT_O signed biases (LAYER_SEQ_BIAS_EN only)
//   in         LENGHT_I unsigned inputs, element 0 in the LSBs
//   out_valid  out holds a complete result
//   out_ready  consumer accepts out
//   out        LENGHT_O unsigned activations, element 0 in the LSBs
//   busy       high while computing (MAC or ACT)
module layer_seq #(
  parameter int LENGHT_I = 4,
  parameter int LENGHT_O = 2,
  parameter int WIDTH_W  = 9,
  parameter int WIDTH_I  = 1,
  parameter int WIDTH_O  = 10,
  parameter int SHIFT    = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LENGHT_I*LENGHT_O*WIDTH_W-1:0]  w_i,
`ifdef LAYER_SEQ_BIAS_EN
  input  logic [LENGHT_O*WIDTH_W-1:0]           b_i,
`endif
  input  logic [LENGHT_I*WIDTH_I-1:0]           in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LENGHT_O*WIDTH_O-1:0]           out,
  output logic                                  busy
);

`ifdef LAYER_SEQ_BIAS_EN
  localparam int WIDTH_A = WIDTH_W + WIDTH_I + $clog2(LENGHT_I) + 2;
`else
  localparam int WIDTH_A = WIDTH_W + WIDTH_I + $clog2(LENGHT_I) + 1;
`endif
  localparam int IW = (LENGHT_I > 1) ? $clog2(LENGHT_I) : 1;
  localparam int OW = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1;
  // Activation arithmetic width: holds the accumulator and the +2^(WIDTH_O-1)
  // offset without wrapping, plus a sign bit.
  localparam int YW = ((WIDTH_A > WIDTH_O + 1) ? WIDTH_A : WIDTH_O + 1) + 1;

  localparam logic [IW-1:0] I_LAST = IW'(LENGHT_I - 1);
  localparam logic [OW-1:0] O_LAST = OW'(LENGHT_O - 1);
  localparam logic signed [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic signed [YW-1:0] Y_ZERO = {YW{1'b0}};
  localparam logic signed [YW-1:0] Y_HALF = Y_ONE << (WIDTH_O - 1);
  localparam logic signed [YW-1:0] Y_MAX  = (Y_ONE << WIDTH_O) - Y_ONE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                              state_r;
  logic [IW-1:0]                       i_r;
  logic [OW-1:0]                       o_r;
  logic signed [WIDTH_A-1:0]           acc_r;
  logic [LENGHT_I*WIDTH_I-1:0]         in_r;
  logic [LENGHT_I*LENGHT_O*WIDTH_W-1:0] w_r;
  logic [LENGHT_O*WIDTH_O-1:0]         out_r;
  logic                                out_valid_r;
  logic                                in_ready_r;
  logic                                busy_r;
`ifdef LAYER_SEQ_BIAS_EN
  logic [LENGHT_O*WIDTH_W-1:0]         b_r;
  logic [WIDTH_W-1:0]                  b_sel_s;
`endif

  logic [WIDTH_W-1:0]                  w_sel_s;
  logic [WIDTH_I-1:0]                  x_sel_s;
  logic signed [WIDTH_A-1:0]           w_ext_s;
  logic signed [WIDTH_A-1:0]           x_ext_s;
  logic signed [WIDTH_A-1:0]           prod_s;
  logic signed [WIDTH_A-1:0]           base_s;
  logic signed [WIDTH_A-1:0]           acc_next_s;
  logic [WIDTH_O-1:0]                  act_s;

  // Hard sigmoid: arithmetic shift (rounds toward -inf), recentre, clamp.
  function automatic logic [WIDTH_O-1:0] hard_sigmoid(input logic signed [WIDTH_A-1:0] a);
    logic signed [WIDTH_A-1:0] s;
    logic signed [YW-1:0]      y;
    s = a >>> SHIFT;
    y = {{(YW-WIDTH_A){s[WIDTH_A-1]}}, s} + Y_HALF;
    if (y < Y_ZERO) begin
      hard_sigmoid = {WIDTH_O{1'b0}};
    end else if (y > Y_MAX) begin
      hard_sigmoid = {WIDTH_O{1'b1}};
    end else begin
      hard_sigmoid = y[WIDTH_O-1:0];
    end
  endfunction

  // Operand selection and next accumulator value for the current (o, i) term.
  always_comb begin
    w_sel_s = {WIDTH_W{1'b0}};
    x_sel_s = {WIDTH_I{1'b0}};
    // AND-OR muxes keep the selects on constant indices.
    for (int ko = 0; ko < LENGHT_O; ko++) begin
      for (int ki = 0; ki < LENGHT_I; ki++) begin
        w_sel_s = w_sel_s | (((o_r == OW'(ko)) && (i_r == IW'(ki)))
                  ? w_r[(ko*LENGHT_I+ki)*WIDTH_W +: WIDTH_W] : {WIDTH_W{1'b0}});
      end
    end
    for (int ki = 0; ki < LENGHT_I; ki++) begin
      x_sel_s = x_sel_s | ((i_r == IW'(ki)) ? in_r[ki*WIDTH_I +: WIDTH_I] : {WIDTH_I{1'b0}});
    end
    w_ext_s = {{(WIDTH_A-WIDTH_W){w_sel_s[WIDTH_W-1]}}, w_sel_s};
    x_ext_s = {{(WIDTH_A-WIDTH_I){1'b0}}, x_sel_s};
    // The true product fits in WIDTH_A, so truncation loses nothing.
    prod_s = w_ext_s * x_ext_s;
`ifdef LAYER_SEQ_BIAS_EN
    b_sel_s = {WIDTH_W{1'b0}};
    for (int ko = 0; ko < LENGHT_O; ko++) begin
      b_sel_s = b_sel_s | ((o_r == OW'(ko)) ? b_r[ko*WIDTH_W +: WIDTH_W] : {WIDTH_W{1'b0}});
    end
    // First term of each neuron starts from the bias instead of the cleared acc.
    base_s = (i_r == {IW{1'b0}}) ? {{(WIDTH_A-WIDTH_W){b_sel_s[WIDTH_W-1]}}, b_sel_s} : acc_r;
`else
    base_s = acc_r;
`endif
    acc_next_s = base_s + prod_s;
    act_s      = hard_sigmoid(acc_r);
  end

  // Sequencer FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      i_r         <= {IW{1'b0}};
      o_r         <= {OW{1'b0}};
      acc_r       <= {WIDTH_A{1'b0}};
      out_r       <= {(LENGHT_O*WIDTH_O){1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            in_r       <= in;
            w_r        <= w_i;
`ifdef LAYER_SEQ_BIAS_EN
            b_r        <= b_i;
`endif
            i_r        <= {IW{1'b0}};
            o_r        <= {OW{1'b0}};
            acc_r      <= {WIDTH_A{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (i_r == I_LAST) begin
            i_r     <= {IW{1'b0}};
            state_r <= ACT;
          end else begin
            i_r <= i_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        ACT: begin
          for (int ko = 0; ko < LENGHT_O; ko++) begin
            if (o_r == OW'(ko)) begin
              out_r[ko*WIDTH_O +: WIDTH_O] <= act_s;
            end
          end
          acc_r <= {WIDTH_A{1'b0}};
          if (o_r == O_LAST) begin
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= DONE;
          end else begin
            o_r     <= o_r + {{(OW-1){1'b0}}, 1'b1};
            i_r     <= {IW{1'b0}};
            state_r <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign busy      = busy_r;

endmodule
